// File: rtl/ps2_keymap_tracker.sv
// ============================================================================
// Module   : ps2_keymap_tracker
// Brief    : PS/2 set-2 scancode decoder with per-key held/press/release tracking
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keymap_tracker #(
  parameter int                        NUM_KEYS    = 4,
  parameter logic [9*NUM_KEYS-1:0]     KEY_CODES   = {9'h172, 9'h175, 9'h01B, 9'h01D},
  parameter int                        TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  input  logic                clear_all,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_key,
  output logic                seq_error
);

  localparam int          C_CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t               r_state;
  logic [2:0]           r_skip;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [NUM_KEYS-1:0]  r_key_state;
  logic [NUM_KEYS-1:0]  r_key_press;
  logic [NUM_KEYS-1:0]  r_key_release;
  logic                 r_any_key;
  logic                 r_seq_error;

  state_t               w_next_state;
  logic [2:0]           w_next_skip;
  logic                 w_make;
  logic                 w_brk;
  logic                 w_ext;
  logic                 w_err;
  logic [8:0]           w_code;
  logic [NUM_KEYS-1:0]  w_match;
  logic [NUM_KEYS-1:0]  w_ks_next;
  logic                 w_is_prefix;
  logic                 w_is_ignored;

  assign w_is_prefix  = (rx_byte == 8'hE0) || (rx_byte == 8'hE1) || (rx_byte == 8'hF0);
  assign w_is_ignored = (rx_byte == 8'hAA) || (rx_byte == 8'hFA) || (rx_byte == 8'hEE) ||
                        (rx_byte == 8'hFE) || (rx_byte == 8'h00) || (rx_byte == 8'hFF);

  always_comb begin
    w_next_state = r_state;
    w_next_skip  = r_skip;
    w_make       = 1'b0;
    w_brk        = 1'b0;
    w_ext        = 1'b0;
    w_err        = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (rx_byte == 8'hE0)      w_next_state = S_EXT;
          else if (rx_byte == 8'hF0) w_next_state = S_BRK;
          else if (rx_byte == 8'hE1) begin
            w_next_state = S_PAUSE;
            w_next_skip  = 3'd7;
          end
          else if (!w_is_ignored)    w_make = 1'b1;
        end
        S_EXT: begin
          if (rx_byte == 8'hF0) w_next_state = S_EXT_BRK;
          else begin
            w_next_state = S_IDLE;
            if ((rx_byte == 8'hE0) || (rx_byte == 8'hE1)) w_err = 1'b1;
            else begin
              w_make = 1'b1;
              w_ext  = 1'b1;
            end
          end
        end
        S_BRK, S_EXT_BRK: begin
          w_next_state = S_IDLE;
          if (w_is_prefix) w_err = 1'b1;
          else begin
            w_brk = 1'b1;
            w_ext = (r_state == S_EXT_BRK);
          end
        end
        S_PAUSE: begin
          // Pause is a fixed 8-byte sequence; the remaining bytes are simply counted off.
          if (r_skip <= 3'd1) w_next_state = S_IDLE;
          else                w_next_skip  = r_skip - 3'd1;
        end
        default: w_next_state = S_IDLE;
      endcase
    end else if ((r_state != S_IDLE) && (r_cnt >= C_TIMEOUT)) begin
      w_next_state = S_IDLE;
      w_err        = 1'b1;
    end
  end

  assign w_code = {w_ext, rx_byte};

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
    assign w_match[gi] = (w_code == KEY_CODES[9*gi +: 9]);
  end

  always_comb begin
    w_ks_next = r_key_state;
    if (clear_all)   w_ks_next = '0;
    else if (w_make) w_ks_next = r_key_state | w_match;
    else if (w_brk)  w_ks_next = r_key_state & ~w_match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_skip        <= 3'd0;
      r_cnt         <= '0;
      r_key_state   <= '0;
      r_key_press   <= '0;
      r_key_release <= '0;
      r_any_key     <= 1'b0;
      r_seq_error   <= 1'b0;
    end else begin
      r_key_state   <= w_ks_next;
      r_key_press   <= w_ks_next & ~r_key_state;
      r_key_release <= r_key_state & ~w_ks_next;
      r_any_key     <= |w_ks_next;
      if (clear_all) begin
        r_state     <= S_IDLE;
        r_skip      <= 3'd0;
        r_cnt       <= '0;
        r_seq_error <= 1'b0;
      end else begin
        r_state     <= w_next_state;
        r_skip      <= w_next_skip;
        r_seq_error <= w_err;
        if (rx_valid || (w_next_state == S_IDLE)) r_cnt <= '0;
        else if (r_cnt != C_TIMEOUT)              r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_state   = r_key_state;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;
  assign any_key     = r_any_key;
  assign seq_error   = r_seq_error;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keymap_tracker.sv
// ============================================================================
// Module   : tb_ps2_keymap_tracker
// Brief    : directed self-checking bench for ps2_keymap_tracker
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_keymap_tracker;

  localparam int C_TIMEOUT = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       clear_all;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       any_key;
  logic       seq_error;

  int n_checks;
  int n_fail;

  ps2_keymap_tracker #(
    .NUM_KEYS   (4),
    .KEY_CODES  ({9'h172, 9'h175, 9'h01B, 9'h01D}),
    .TIMEOUT_CYC(C_TIMEOUT)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .clear_all  (clear_all),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .any_key    (any_key),
    .seq_error  (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    logic [7:0] pause_seq [8];
    n_checks  = 0;
    n_fail    = 0;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    clear_all = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",   32'(key_state),   32'h0);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_any",     32'(any_key),     32'h0);
    chk("rst_err",     32'(seq_error),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // plain make/break of key0
    send(8'h1D);
    chk("w_make_state", 32'(key_state), 32'h1);
    chk("w_make_press", 32'(key_press), 32'h1);
    chk("w_make_any",   32'(any_key),   32'h1);
    idle_cycle();
    chk("w_press_1cyc", 32'(key_press), 32'h0);
    send(8'hF0);
    chk("w_f0_state",   32'(key_state),   32'h1);
    chk("w_f0_release", 32'(key_release), 32'h0);
    send(8'h1D);
    chk("w_brk_state",   32'(key_state),   32'h0);
    chk("w_brk_release", 32'(key_release), 32'h1);
    chk("w_brk_any",     32'(any_key),     32'h0);

    // extended key with typematic repeat
    send(8'hE0); send(8'h75);
    chk("up_make_state", 32'(key_state), 32'h4);
    chk("up_make_press", 32'(key_press), 32'h4);
    for (int i = 0; i < 2; i++) begin
      send(8'hE0); send(8'h75);
      chk("up_rep_state", 32'(key_state), 32'h4);
      chk("up_rep_press", 32'(key_press), 32'h0);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_brk_state",   32'(key_state),   32'h0);
    chk("up_brk_release", 32'(key_release), 32'h4);

    // extended vs plain code 72
    send(8'hE0); send(8'h72);
    chk("dn_make_state", 32'(key_state), 32'h8);
    send(8'hE0); send(8'hF0); send(8'h72);
    chk("dn_brk_release", 32'(key_release), 32'h8);
    send(8'h72);
    chk("kp2_state", 32'(key_state), 32'h0);
    chk("kp2_press", 32'(key_press), 32'h0);

    // pause sequence is swallowed
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      chk("pause_state", 32'(key_state), 32'h0);
      chk("pause_err",   32'(seq_error), 32'h0);
    end
    send(8'h1B);
    chk("after_pause_state", 32'(key_state), 32'h2);
    chk("after_pause_press", 32'(key_press), 32'h2);
    send(8'hF0); send(8'h1B);
    chk("s_brk_state", 32'(key_state), 32'h0);

    // illegal byte in prefix state
    send(8'hE0); send(8'hE0);
    chk("e0e0_err", 32'(seq_error), 32'h1);
    idle_cycle();
    chk("e0e0_err_1cyc", 32'(seq_error), 32'h0);
    send(8'h1D);
    chk("e0e0_then_make", 32'(key_state), 32'h1);
    send(8'hF0); send(8'h1D);

    // timeout abort after a dangling F0
    send(8'hF0);
    for (int i = 0; i < C_TIMEOUT / 2; i++) begin
      idle_cycle();
      if (seq_error) pulses = -100;
    end
    chk("to_no_early", 32'(seq_error), 32'h0);
    pulses = 0;
    for (int i = 0; i < C_TIMEOUT + 10; i++) begin
      idle_cycle();
      if (seq_error) pulses++;
    end
    chk("to_one_pulse", 32'(pulses), 32'h1);
    send(8'h1D);
    chk("to_then_make",  32'(key_state), 32'h1);
    chk("to_then_press", 32'(key_press), 32'h1);

    // clear_all beats a same-cycle prefix byte
    send(8'h1B);
    chk("two_held", 32'(key_state), 32'h3);
    @(negedge clk);
    clear_all = 1'b1;
    rx_byte   = 8'hE0;
    rx_valid  = 1'b1;
    @(posedge clk);
    #1;
    clear_all = 1'b0;
    rx_valid  = 1'b0;
    chk("clr_state",   32'(key_state),   32'h0);
    chk("clr_release", 32'(key_release), 32'h3);
    chk("clr_err",     32'(seq_error),   32'h0);
    chk("clr_any",     32'(any_key),     32'h0);
    send(8'h75);
    chk("clr_e0_dropped", 32'(key_state), 32'h0);

    // reset mid-sequence discards the prefix
    send(8'hE0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    send(8'h75);
    chk("rst_mid_seq", 32'(key_state), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
